// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes (minuend - subtrahend) one bit per
// clock, LSB first, with a ready/valid handshake on both operands and result.
//
// state | meaning
// IDLE  | waiting for an operation; start_ready high
// SHIFT | processing one operand bit per cycle; busy high
// DONE  | diff/borrow_out valid, held until result_ready
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             bw;
    logic             bw_next;
    logic             d_bit;
    logic             last_bit;
    logic             accept;

    assign d_bit    = a_sr[0] ^ b_sr[0] ^ bw;
    assign bw_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bw);
    // Shift the new bit in at the MSB; written as shifts so WIDTH=1 stays legal.
    assign res_next = (res_sr >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign accept   = start_valid & start_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        start_ready  = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) state_next = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
                if (result_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // diff/borrow_out are separate registers loaded only on the final bit, so
    // they keep their last value through IDLE and SHIFT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            bw         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_next;
            bw     <= bw_next;
            cnt    <= cnt + CW'(1);
            if (last_bit) begin
                diff       <= res_next;
                borrow_out <= bw_next;
            end
        end else if (accept) begin
            a_sr <= minuend;
            b_sr <= subtrahend;
            bw   <= 1'b0;
            cnt  <= '0;
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vectors, handshake and
// reset corner cases, a WIDTH=1 instance, and a randomized scoreboard run.
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       sv8, sr8, bo8, rv8, rr8, busy8;
    logic [7:0] min8, sub8, diff8;

    logic       sv1, sr1, bo1, rv1, rr1, busy1;
    logic [0:0] min1, sub1, diff1;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset),
        .start_valid(sv8), .start_ready(sr8),
        .minuend(min8), .subtrahend(sub8),
        .diff(diff8), .borrow_out(bo8),
        .result_valid(rv8), .result_ready(rr8), .busy(busy8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset),
        .start_valid(sv1), .start_ready(sr1),
        .minuend(min1), .subtrahend(sub1),
        .diff(diff1), .borrow_out(bo1),
        .result_valid(rv1), .result_ready(rr1), .busy(busy1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bw;
    } vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
    } op_t;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[6];
    op_t  sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept an operation on the next edge, then scramble the operand pins.
    task automatic start8(input logic [7:0] a, input logic [7:0] b);
        min8 = a;
        sub8 = b;
        sv8  = 1'b1;
        tick();
        sv8  = 1'b0;
        min8 = 8'($urandom);
        sub8 = 8'($urandom);
    endtask

    // Called just after the accept edge; expects result_valid after 8 edges.
    task automatic finish8(input string name, input logic [7:0] ed, input logic eb);
        int lat = 0;
        while (rv8 !== 1'b1 && lat < 20) begin
            chk({name, "_busy"}, busy8, 1);
            tick();
            lat++;
        end
        chk({name, "_latency"}, lat, 8);
        chk({name, "_diff"}, diff8, ed);
        chk({name, "_borrow"}, bo8, eb);
        chk({name, "_busy_done"}, busy8, 0);
        chk({name, "_sready_done"}, sr8, 0);
    endtask

    task automatic consume8(input string name);
        rr8 = 1'b1;
        tick();
        rr8 = 1'b0;
        chk({name, "_idle_sready"}, sr8, 1);
        chk({name, "_idle_rvalid"}, rv8, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ta, tbit, ed1, eb1;
        logic [7:0] ra, rb, exp_d;
        logic       exp_b;
        op_t        op;
        int         sent, got, cyc;
        bit         pushed;

        tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
        tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
        tbl[2] = '{8'h00, 8'hFF, 8'h01, 1'b1};
        tbl[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        tbl[4] = '{8'h80, 8'h01, 8'h7F, 1'b0};
        tbl[5] = '{8'h00, 8'h01, 8'hFF, 1'b1};

        sv8 = 0; rr8 = 0; min8 = 0; sub8 = 0;
        sv1 = 0; rr1 = 0; min1 = 0; sub1 = 0;
        reset = 1'b1;
        #3;
        chk("rst_sready", sr8, 1);
        chk("rst_busy", busy8, 0);
        chk("rst_rvalid", rv8, 0);
        chk("rst_diff", diff8, 0);
        chk("rst_borrow", bo8, 0);
        chk("rst1_sready", sr1, 1);
        #10;
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            start8(tbl[i].a, tbl[i].b);
            finish8($sformatf("vec%0d", i), tbl[i].d, tbl[i].bw);
            consume8($sformatf("vec%0d", i));
        end

        // Back-pressure: hold DONE for 5 cycles while wiggling inputs.
        start8(8'h37, 8'h12);
        finish8("bp", 8'h25, 1'b0);
        for (int i = 0; i < 5; i++) begin
            min8 = 8'($urandom);
            sub8 = 8'($urandom);
            sv8  = ~sv8;
            tick();
            chk("bp_hold_diff", diff8, 8'h25);
            chk("bp_hold_borrow", bo8, 0);
            chk("bp_hold_sready", sr8, 0);
            chk("bp_hold_rvalid", rv8, 1);
            chk("bp_hold_busy", busy8, 0);
        end
        // Release with start_valid also high: consume now, accept one edge later.
        min8 = 8'h20;
        sub8 = 8'h08;
        sv8  = 1'b1;
        rr8  = 1'b1;
        tick();
        rr8 = 1'b0;
        chk("bp_release_sready", sr8, 1);
        chk("bp_release_busy", busy8, 0);
        chk("bp_release_rvalid", rv8, 0);
        tick();
        sv8  = 1'b0;
        min8 = 8'($urandom);
        sub8 = 8'($urandom);
        chk("bp_next_busy", busy8, 1);
        finish8("bp_next", 8'h18, 1'b0);
        consume8("bp_next");

        // Reset in the middle of SHIFT.
        start8(8'hAA, 8'h55);
        for (int i = 0; i < 4; i++) tick();
        chk("mid_busy_pre", busy8, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy8, 0);
        chk("mid_rst_rvalid", rv8, 0);
        chk("mid_rst_sready", sr8, 1);
        chk("mid_rst_diff", diff8, 0);
        #2;
        reset = 1'b0;
        tick();
        chk("mid_after_rvalid", rv8, 0);
        start8(8'h10, 8'h01);
        finish8("mid_after", 8'h0F, 1'b0);
        consume8("mid_after");

        // WIDTH=1: full subtractor with zero borrow-in, one edge latency.
        for (int i = 0; i < 4; i++) begin
            ta   = (i & 2) != 0;
            tbit = (i & 1) != 0;
            ed1  = ta ^ tbit;
            eb1  = ~ta & tbit;
            min1 = ta;
            sub1 = tbit;
            sv1  = 1'b1;
            tick();
            sv1  = 1'b0;
            min1 = ~min1;
            sub1 = ~sub1;
            chk($sformatf("w1_%0d_busy", i), busy1, 1);
            tick();
            chk($sformatf("w1_%0d_rvalid", i), rv1, 1);
            chk($sformatf("w1_%0d_diff", i), diff1, ed1);
            chk($sformatf("w1_%0d_borrow", i), bo1, eb1);
            rr1 = 1'b1;
            tick();
            rr1 = 1'b0;
            chk($sformatf("w1_%0d_idle", i), sr1, 1);
        end

        // 200 random back-to-back operations against an arithmetic model.
        rr8  = 1'b1;
        sv8  = 1'b1;
        min8 = 8'($urandom);
        sub8 = 8'($urandom);
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 200 && cyc < 5000) begin
            if (rv8 === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("rand_extra_result", rv8, 0);
                end else begin
                    op    = sb.pop_front();
                    exp_d = 8'((int'(op.a) - int'(op.b) + 256) % 256);
                    exp_b = (op.a < op.b);
                    chk("rand_diff", diff8, exp_d);
                    chk("rand_borrow", bo8, exp_b);
                end
                got++;
            end
            pushed = 1'b0;
            if (sr8 === 1'b1 && sv8 === 1'b1) begin
                sb.push_back('{min8, sub8});
                sent++;
                pushed = 1'b1;
            end
            tick();
            cyc++;
            if (pushed) begin
                if (sent >= 200) begin
                    sv8 = 1'b0;
                end else begin
                    ra   = 8'($urandom);
                    rb   = 8'($urandom);
                    min8 = ra;
                    sub8 = rb;
                end
            end else if (busy8 === 1'b1) begin
                min8 = 8'($urandom);
                sub8 = 8'($urandom);
            end
        end
        chk("rand_results", got, 200);
        chk("rand_accepts", sent, 200);
        chk("rand_queue_empty", sb.size(), 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("rand_no_extra", rv8, 0);
        end
        rr8 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the operand and result width in bits; legal range 1..32.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start_valid  input  1  operands present and a new operation is requested.
REQ-005 SHALL have port start_ready  output  1  block can accept an operation.
REQ-006 SHALL have port minuend  input  WIDTH  unsigned operand A, sampled on accept.
REQ-007 SHALL have port subtrahend  input  WIDTH  unsigned operand B, sampled on accept.
REQ-008 SHALL have port diff  output  WIDTH  result (A - B) mod 2^WIDTH.
REQ-009 SHALL have port borrow_out  output  1  final borrow; 1 iff A < B unsigned.
REQ-010 SHALL have port result_valid  output  1  diff/borrow_out are valid.
REQ-011 SHALL have port result_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port busy  output  1  high while the operation is in progress (SHIFT state).

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE; it SHALL be in IDLE after reset.
REQ-014 SHALL drive start_ready=1 only in IDLE; busy=1 only in SHIFT; result_valid=1 only in DONE.
REQ-015 Accept SHALL occur on the rising edge where start_valid=1 and start_ready=1; it SHALL load A and B into shift registers, clear the borrow flop and the bit counter, and move to SHIFT.
REQ-016 Each SHIFT cycle SHALL process one bit, LSB first: d = a0 ^ b0 ^ bw; bw_next = (~a0 & b0) | (~(a0 ^ b0) & bw).
REQ-017 Each SHIFT cycle SHALL shift A and B right by one and shift d into the MSB of the result register.
REQ-018 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL increment once per SHIFT cycle.
REQ-019 SHALL move SHIFT->DONE on the edge that processes bit WIDTH-1, so result_valid rises exactly WIDTH clock edges after the accept edge.
REQ-020 diff and borrow_out SHALL hold the final values and stay stable throughout DONE.
REQ-021 SHALL move DONE->IDLE on the edge where result_ready=1.
REQ-022 start_valid SHALL be ignored outside IDLE, with no effect on the operation in progress.
REQ-023 result_ready SHALL be ignored outside DONE.
REQ-024 If result_ready and start_valid are both high in DONE, the result SHALL be consumed and the new operation SHALL be accepted on the next cycle, not the same edge.
REQ-025 Changes on minuend or subtrahend after accept SHALL NOT affect the result.
REQ-026 diff and borrow_out are don't-care outside DONE; the implementation SHALL nevertheless leave them unchanged from their last written value.
REQ-027 WIDTH=1 SHALL behave as a one-bit full subtractor with borrow-in 0, with result_valid one edge after accept.

Reset
REQ-028 Asserting reset SHALL immediately, without waiting for clk, force:
- state IDLE
- start_ready=1
- busy=0
- result_valid=0
- diff=0, borrow_out=0
- internal shift registers, borrow flop and counter cleared
REQ-029 Reset asserted mid-SHIFT or in DONE SHALL abort the operation with no result produced; the first accept after deassertion SHALL behave as from power-up.

Verification
REQ-030 The bench SHALL check, for WIDTH=8, A=0x05, B=0x03, accepted at edge E0 -> result_valid high after E8, diff=0x02, borrow_out=0, busy high during E1..E8.
REQ-031 The bench SHALL check A=0x03, B=0x05 -> diff=0xFE, borrow_out=1; and A=0x00, B=0xFF -> diff=0x01, borrow_out=1; and A=0xFF, B=0xFF -> diff=0x00, borrow_out=0.
REQ-032 The bench SHALL check back-pressure: hold result_ready=0 for 5 cycles in DONE while toggling minuend, subtrahend and start_valid -> diff and borrow_out stable, start_ready=0, no new accept; releasing result_ready -> IDLE on the next edge.
REQ-033 The bench SHALL check reset mid-operation: assert reset 4 cycles after accepting A=0xAA, B=0x55 -> busy=0, result_valid=0, start_ready=1 with no clock edge; then accept A=0x10, B=0x01 -> diff=0x0F, borrow_out=0.
REQ-034 The bench SHALL check WIDTH=1 exhaustively over the 4 combinations of (A,B) -> diff=A^B, borrow_out=~A&B, result_valid one edge after accept.
REQ-035 The bench SHALL run 200 random 8-bit operand pairs back-to-back with result_ready held at 1 -> every result equals (A-B) mod 256 with borrow_out = (A<B), and exactly one result per accept; the error count SHALL be 0 at end.
